// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
// Holds FSM state encoding, one-hot size codes and the latched command.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [2:0] SZ_W = 3'b100;
   localparam logic [2:0] SZ_H = 3'b010;
   localparam logic [2:0] SZ_B = 3'b001;

   typedef struct packed {
      logic       b;
      logic       we;
      logic [2:0] size;
      logic       sext;
   } cmd_t;

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: request legality check and big-endian load
// extraction with sign/zero extension.
module dmem_load_ext
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic [2:0]  chk_size,
   input  logic [31:0] chk_addr,
   output logic        chk_err,
   input  logic        we,
   input  logic [2:0]  size,
   input  logic        sext,
   input  logic [31:0] m_rdata,
   output logic [31:0] rdata
);

   always_comb begin
      chk_err = 1'b0;
      if (!(chk_size inside {SZ_W, SZ_H, SZ_B}))
         chk_err = 1'b1;
      if (chk_size == SZ_H && chk_addr[0])
         chk_err = 1'b1;
      if (chk_size == SZ_W && chk_addr[1:0] != 2'b00)
         chk_err = 1'b1;
      if ((chk_addr >> ADDR_W) != 32'd0)
         chk_err = 1'b1;
   end

   // Addressed byte sits in the top lane of m_rdata.
   always_comb begin
      rdata = '0;
      if (!we) begin
         unique case (size)
            SZ_W: rdata = m_rdata;
            SZ_H: rdata = {{16{sext & m_rdata[31]}}, m_rdata[31:16]};
            SZ_B: rdata = {{24{sext & m_rdata[31]}}, m_rdata[31:24]};
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: round-robin arbiter between the load/store unit (A) and
// the debug/loader port (B) onto a single-cycle data memory.
module dmem_arb
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        b_req,
   input  logic        a_we,
   input  logic        b_we,
   input  logic [2:0]  a_size,
   input  logic [2:0]  b_size,
   input  logic        a_sext,
   input  logic        b_sext,
   input  logic [31:0] a_addr,
   input  logic [31:0] b_addr,
   input  logic [31:0] a_wdata,
   input  logic [31:0] b_wdata,
   output logic        a_gnt,
   output logic        b_gnt,
   output logic        a_done,
   output logic        b_done,
   output logic        a_err,
   output logic        b_err,
   output logic [31:0] a_rdata,
   output logic [31:0] b_rdata,
   output logic        m_cs,
   output logic        m_w,
   output logic        m_r,
   output logic [2:0]  m_sel,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   state_t      state, state_nx;
   cmd_t        cmd, req_cmd;
   logic [31:0] req_addr, req_wdata;
   logic        prio_b, pick_b, grant, req_err;
   logic [31:0] ext_data;

   always_comb begin
      pick_b       = b_req & (~a_req | prio_b);
      req_cmd.b    = pick_b;
      req_cmd.we   = pick_b ? b_we : a_we;
      req_cmd.size = pick_b ? b_size : a_size;
      req_cmd.sext = pick_b ? b_sext : a_sext;
      req_addr     = pick_b ? b_addr : a_addr;
      req_wdata    = pick_b ? b_wdata : a_wdata;
   end

   dmem_load_ext #(.ADDR_W(ADDR_W)) u_ext (
      .chk_size (req_cmd.size),
      .chk_addr (req_addr),
      .chk_err  (req_err),
      .we       (cmd.we),
      .size     (cmd.size),
      .sext     (cmd.sext),
      .m_rdata  (m_rdata),
      .rdata    (ext_data)
   );

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rst && (a_req || b_req)) begin
               grant    = 1'b1;
               a_gnt    = ~pick_b;
               b_gnt    = pick_b;
               state_nx = req_err ? DONE : ACCESS;
            end
         end
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cmd     <= '0;
         prio_b  <= 1'b0;
         m_cs    <= 1'b0;
         m_w     <= 1'b0;
         m_r     <= 1'b0;
         m_sel   <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         a_done  <= 1'b0;
         b_done  <= 1'b0;
         a_err   <= 1'b0;
         b_err   <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state   <= state_nx;
         m_cs    <= 1'b0;
         m_w     <= 1'b0;
         m_r     <= 1'b0;
         m_sel   <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         a_done  <= 1'b0;
         b_done  <= 1'b0;
         a_err   <= 1'b0;
         b_err   <= 1'b0;
         if (grant) begin
            cmd    <= req_cmd;
            prio_b <= ~pick_b;
            if (req_err) begin
               // Illegal request skips the memory cycle entirely.
               a_done <= ~pick_b;
               b_done <= pick_b;
               a_err  <= ~pick_b;
               b_err  <= pick_b;
               if (pick_b) b_rdata <= '0;
               else        a_rdata <= '0;
            end else begin
               m_cs    <= 1'b1;
               m_w     <= req_cmd.we;
               m_r     <= ~req_cmd.we;
               m_sel   <= req_cmd.size;
               m_addr  <= req_addr;
               m_wdata <= req_wdata;
            end
         end
         if (state == ACCESS) begin
            a_done <= ~cmd.b;
            b_done <= cmd.b;
            if (cmd.b) b_rdata <= ext_data;
            else       a_rdata <= ext_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed table, corner sequences and randomized
// traffic checked against a byte-array reference model.
module tb_dmem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req, a_we, b_we, a_sext, b_sext;
   logic [2:0]  a_size, b_size;
   logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_done, b_done, a_err, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        m_cs, m_w, m_r;
   logic [2:0]  m_sel;
   logic [31:0] m_addr, m_wdata, m_rdata;

   always #5 clk = ~clk;

   dmem_arb #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
      .a_size(a_size), .b_size(b_size), .a_sext(a_sext), .b_sext(b_sext),
      .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
      .a_err(a_err), .b_err(b_err), .a_rdata(a_rdata), .b_rdata(b_rdata),
      .m_cs(m_cs), .m_w(m_w), .m_r(m_r), .m_sel(m_sel),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   // Memory device: big-endian, writes on the falling edge.
   logic [7:0] mem [256];
   logic [7:0] ma;
   assign ma = m_addr[7:0];
   assign m_rdata = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

   always @(negedge clk) begin
      if (m_cs && m_w) begin
         case (m_sel)
            3'b100: begin
               mem[ma]        <= m_wdata[31:24];
               mem[ma + 8'd1] <= m_wdata[23:16];
               mem[ma + 8'd2] <= m_wdata[15:8];
               mem[ma + 8'd3] <= m_wdata[7:0];
            end
            3'b010: begin
               mem[ma]        <= m_wdata[15:8];
               mem[ma + 8'd1] <= m_wdata[7:0];
            end
            3'b001: mem[ma] <= m_wdata[7:0];
            default: ;
         endcase
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_s;

   typedef struct {
      bit          ar, br;
      cmd_s        ca, cb;
      bit          eb, ee;
      logic [31:0] erd;
      string       nm;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   ref_mem [256];
   bit   last_b;
   vec_t vt [$];
   cmd_s nop;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic cmd_s mk(bit we, logic [2:0] sz, bit sx, logic [31:0] ad, logic [31:0] wd);
      cmd_s c;
      c.we = we; c.size = sz; c.sext = sx; c.addr = ad; c.wdata = wd;
      return c;
   endfunction

   function automatic int nbytes(logic [2:0] sz);
      return (sz == 3'b100) ? 4 : (sz == 3'b010) ? 2 : 1;
   endfunction

   // Reference: legality from the access rules, data from byte array.
   function automatic void model(input cmd_s c, output bit err, output logic [31:0] rd);
      longint v;
      int     n, a;
      err = !(c.size == 3'b100 || c.size == 3'b010 || c.size == 3'b001)
            || c.addr > 32'd255
            || (c.size == 3'b010 && c.addr % 2 != 0)
            || (c.size == 3'b100 && c.addr % 4 != 0);
      rd = '0;
      if (err || c.we) return;
      n = nbytes(c.size);
      a = int'(c.addr);
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + ref_mem[(a + i) % 256];
      if (c.sext && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= (longint'(1) << (8 * n));
      rd = v[31:0];
   endfunction

   task automatic model_store(input cmd_s c);
      longint val;
      int     n, a;
      n   = nbytes(c.size);
      a   = int'(c.addr);
      val = longint'(c.wdata);
      for (int i = n - 1; i >= 0; i--) begin
         ref_mem[(a + i) % 256] = int'(val % 256);
         val = val / 256;
      end
   endtask

   task automatic drive(input bit ar, input bit br, input cmd_s ca, input cmd_s cb);
      a_req = ar; b_req = br;
      a_we = ca.we; a_size = ca.size; a_sext = ca.sext;
      a_addr = ca.addr; a_wdata = ca.wdata;
      b_we = cb.we; b_size = cb.size; b_sext = cb.sext;
      b_addr = cb.addr; b_wdata = cb.wdata;
   endtask

   // Caller positions at #1 after the rising edge of an IDLE cycle.
   task automatic txn(input bit ar, input bit br, input cmd_s ca, input cmd_s cb,
                      input bit eb, input bit ee, input logic [31:0] erd, input string nm);
      cmd_s c;
      c = eb ? cb : ca;
      drive(ar, br, ca, cb);
      @(negedge clk);
      chk({nm, " gnt"}, {30'd0, a_gnt, b_gnt}, {30'd0, !eb, eb});
      chk({nm, " cs0"}, {31'd0, m_cs}, 32'd0);
      last_b = eb;
      @(negedge clk);
      if (ee) begin
         chk({nm, " errdone"}, {27'd0, a_done, b_done, a_err, b_err, m_cs},
             {27'd0, !eb, eb, !eb, eb, 1'b0});
      end else begin
         chk({nm, " bus"}, {26'd0, m_cs, m_w, m_r, m_sel, a_done, b_done},
             {26'd0, 1'b1, c.we, !c.we, c.size, 2'b00});
         chk({nm, " maddr"}, m_addr, c.addr);
         if (c.we) chk({nm, " mwdata"}, m_wdata, c.wdata);
         @(negedge clk);
         chk({nm, " done"}, {26'd0, a_done, b_done, a_err, b_err, m_cs, a_gnt | b_gnt},
             {26'd0, !eb, eb, 4'b0000});
         chk({nm, " rdata"}, eb ? b_rdata : a_rdata, erd);
         chk({nm, " bus0"}, m_addr, 32'd0);
         if (c.we) model_store(c);
      end
   endtask

   task automatic add(input bit ar, input bit br, input cmd_s ca, input cmd_s cb,
                      input bit eb, input bit ee, input logic [31:0] erd, input string nm);
      vec_t v;
      v.ar = ar; v.br = br; v.ca = ca; v.cb = cb;
      v.eb = eb; v.ee = ee; v.erd = erd; v.nm = nm;
      vt.push_back(v);
   endtask

   function automatic cmd_s rnd_cmd();
      cmd_s c;
      int   r;
      c.we    = 1'($urandom_range(0, 1));
      c.sext  = 1'($urandom_range(0, 1));
      c.wdata = $urandom;
      r = $urandom_range(0, 9);
      c.size = (r < 3) ? 3'b100 : (r < 6) ? 3'b010 : (r < 9) ? 3'b001 : 3'($urandom_range(0, 7));
      r = $urandom_range(0, 15);
      if (r == 0)      c.addr = 32'h100 + $urandom_range(0, 255);
      else if (r == 1) c.addr = $urandom;
      else begin
         c.addr = $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) begin
            if (c.size == 3'b100) c.addr[1:0] = 2'b00;
            if (c.size == 3'b010) c.addr[0] = 1'b0;
         end
      end
      return c;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cmd_s ca, cb;
      bit   ar, br, eb, ee;
      logic [31:0] erd;

      nop = mk(0, 3'b100, 0, 32'h0, 32'h0);
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = int'(mem[i]);
      end
      mem[8'h10] = 8'h89; mem[8'h11] = 8'hAB; mem[8'h12] = 8'hCD; mem[8'h13] = 8'hEF;
      mem[8'h05] = 8'h80;
      ref_mem[16] = 'h89; ref_mem[17] = 'hAB; ref_mem[18] = 'hCD; ref_mem[19] = 'hEF;
      ref_mem[5] = 'h80;

      // Both requesters high throughout reset, then alternate.
      rst = 1'b1;
      ca = mk(0, 3'b100, 0, 32'h10, 32'h0);
      cb = mk(0, 3'b001, 1, 32'h05, 32'h0);
      drive(1, 1, ca, cb);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ctl", {23'd0, a_gnt, b_gnt, a_done, b_done, a_err, b_err, m_cs, m_w, m_r},
          32'd0);
      chk("reset bus", {29'd0, m_sel} | m_addr | m_wdata | a_rdata | b_rdata, 32'd0);
      step;
      rst = 1'b0;
      last_b = 1'b1;
      txn(1, 1, ca, cb, 0, 0, 32'h89ABCDEF, "rr0");
      step; txn(1, 1, ca, cb, 1, 0, 32'hFFFFFF80, "rr1");
      step; txn(1, 1, ca, cb, 0, 0, 32'h89ABCDEF, "rr2");
      step; txn(1, 1, ca, cb, 1, 0, 32'hFFFFFF80, "rr3");
      step; drive(0, 0, nop, nop);

      add(1, 0, mk(0, 3'b100, 0, 32'h10, 0), nop, 0, 0, 32'h89ABCDEF, "lw10");
      add(0, 1, nop, mk(0, 3'b001, 1, 32'h05, 0), 1, 0, 32'hFFFFFF80, "lbs05");
      add(0, 1, nop, mk(0, 3'b001, 0, 32'h05, 0), 1, 0, 32'h00000080, "lbu05");
      add(1, 0, mk(1, 3'b010, 0, 32'h03, 32'h1234), nop, 0, 1, 32'h0, "shmis");
      add(1, 0, mk(0, 3'b100, 0, 32'h100, 0), nop, 0, 1, 32'h0, "lwoor");
      add(1, 0, mk(1, 3'b100, 0, 32'h20, 32'h11223344), nop, 0, 0, 32'h0, "sw20");
      add(1, 0, mk(0, 3'b100, 0, 32'h20, 0), nop, 0, 0, 32'h11223344, "lw20");
      add(1, 1, mk(0, 3'b100, 0, 32'h10, 0), mk(0, 3'b010, 1, 32'h10, 0),
          1, 0, 32'hFFFF89AB, "tieb");
      add(1, 1, mk(0, 3'b010, 0, 32'h12, 0), mk(0, 3'b001, 0, 32'h10, 0),
          0, 0, 32'h0000CDEF, "tiea");
      add(1, 0, mk(0, 3'b011, 0, 32'h10, 0), nop, 0, 1, 32'h0, "badsz");
      add(0, 1, nop, mk(0, 3'b001, 1, 32'h13, 0), 1, 0, 32'hFFFFFFEF, "lbs13");
      add(0, 1, nop, mk(0, 3'b100, 0, 32'h22, 0), 1, 1, 32'h0, "lwmis");
      add(0, 1, nop, mk(1, 3'b001, 0, 32'h30, 32'hFFFFFF5A), 1, 0, 32'h0, "sb30");
      add(0, 1, nop, mk(0, 3'b001, 0, 32'h30, 0), 1, 0, 32'h0000005A, "lbu30");

      for (int i = 0; i < vt.size(); i++) begin
         step;
         txn(vt[i].ar, vt[i].br, vt[i].ca, vt[i].cb, vt[i].eb, vt[i].ee, vt[i].erd, vt[i].nm);
      end
      step; drive(0, 0, nop, nop);

      // Reset during the ACCESS cycle of a B load.
      step;
      drive(0, 1, nop, mk(0, 3'b100, 0, 32'h10, 0));
      @(negedge clk);
      chk("abort gnt", {31'd0, b_gnt}, 32'd1);
      @(negedge clk);
      chk("abort cs", {31'd0, m_cs}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort ctl", {23'd0, a_gnt, b_gnt, a_done, b_done, a_err, b_err, m_cs, m_w, m_r},
          32'd0);
      chk("abort data", {29'd0, m_sel} | m_addr | b_rdata | a_rdata, 32'd0);
      last_b = 1'b1;
      step;
      rst = 1'b0;
      txn(1, 1, mk(0, 3'b001, 0, 32'h05, 0), mk(0, 3'b100, 0, 32'h10, 0),
          0, 0, 32'h00000080, "postrst");

      for (int i = 0; i < 60; i++) begin
         step;
         ar = 1'($urandom_range(0, 1));
         br = 1'($urandom_range(0, 1));
         if (!ar && !br) ar = 1'b1;
         ca = rnd_cmd();
         cb = rnd_cmd();
         eb = br && (!ar || !last_b);
         model(eb ? cb : ca, ee, erd);
         txn(ar, br, ca, cb, eb, ee, erd, $sformatf("rnd%0d", i));
         if ($urandom_range(0, 2) == 0) begin
            step;
            drive(0, 0, nop, nop);
         end
      end

      step;
      drive(0, 0, nop, nop);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
